// File: rtl/sync_pkg.sv
// Shared constants and state encoding for the sync-train sequencer.
package sync_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int NPER_W_DEF = 16;

    // Software-facing defaults. The datapath takes everything at runtime.
    localparam int FREQ_CLK = 2000000;
    localparam logic [CNT_W_DEF-1:0] DEFAULT_HALF_PERIOD = CNT_W_DEF'(FREQ_CLK);
    localparam logic [CNT_W_DEF-1:0] DEFAULT_DELAY       = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_tick_gen.sv
// Loadable down-counter. tick is high while enabled and the count has
// reached zero; the owner reloads on that cycle to get a periodic tick.
module sync_tick_gen
    import sync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down to zero and park there.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/sync_train_sequencer.sv
// Run controller for the syncout pin: latch config on start, wait D cycles,
// emit N square-wave periods of half-period H (or run until abort if N=0).
module sync_train_sequencer
    import sync_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NPER_W = NPER_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [NPER_W-1:0] cfg_num_periods,
    output logic              busy,
    output logic              done,
    output logic              syncout,
    output logic [NPER_W-1:0] period_count
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic [NPER_W-1:0]   nper_q, nper_d;
    logic                syncout_q, syncout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NPER_W-1:0]   period_count_q, period_count_d;

    logic                tick;
    logic                tick_load;
    logic                tick_en;
    logic [CNT_W-1:0]    tick_value;
    logic [CNT_W-1:0]    half_eff;

    // One counter serves both the start delay and the half-period timing.
    sync_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .load       (tick_load),
        .load_value (tick_value),
        .enable     (tick_en),
        .tick       (tick)
    );

    // Next-state, registered-output and counter-reload decisions.
    always_comb begin
        state_d        = state_q;
        half_d         = half_q;
        nper_d         = nper_q;
        syncout_d      = syncout_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        period_count_d = period_count_q;
        tick_load      = 1'b0;
        tick_value     = half_q - CNT_W'(1);
        tick_en        = (state_q == DELAY) || (state_q == RUN);
        half_eff       = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;

        if ((state_q != IDLE) && abort) begin
            // Abort beats everything, including a terminal count this cycle.
            state_d   = IDLE;
            syncout_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        half_d         = half_eff;
                        nper_d         = cfg_num_periods;
                        period_count_d = '0;
                        busy_d         = 1'b1;
                        tick_load      = 1'b1;
                        if (cfg_delay != '0) begin
                            tick_value = cfg_delay - CNT_W'(1);
                            state_d    = DELAY;
                        end else begin
                            tick_value = half_eff - CNT_W'(1);
                            state_d    = RUN;
                        end
                    end
                end
                DELAY: begin
                    if (tick) begin
                        state_d   = RUN;
                        tick_load = 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (!syncout_q) begin
                            syncout_d      = 1'b1;
                            period_count_d = period_count_q + NPER_W'(1);
                            tick_load      = 1'b1;
                        end else begin
                            syncout_d = 1'b0;
                            // Terminal check on the falling edge so the train ends low.
                            if ((nper_q != '0) && (period_count_q == nper_q)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                tick_load = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    syncout_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            half_q         <= '0;
            nper_q         <= '0;
            syncout_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            half_q         <= half_d;
            nper_q         <= nper_d;
            syncout_q      <= syncout_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            period_count_q <= period_count_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign syncout      = syncout_q;
    assign period_count = period_count_q;

endmodule

// File: tb/tb_sync_train_sequencer.sv
// Directed bench for sync_train_sequencer with hand-derived expectations.
module tb_sync_train_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] cfg_half_period;
    logic [31:0] cfg_delay;
    logic [15:0] cfg_num_periods;
    logic        busy;
    logic        done;
    logic        syncout;
    logic [15:0] period_count;

    int checks   = 0;
    int failures = 0;

    sync_train_sequencer #(
        .CNT_W  (32),
        .NPER_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_half_period (cfg_half_period),
        .cfg_delay       (cfg_delay),
        .cfg_num_periods (cfg_num_periods),
        .busy            (busy),
        .done            (done),
        .syncout         (syncout),
        .period_count    (period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input logic s, input int pc,
                           input logic d, input logic b);
        chk({tag, "_syncout"}, e, 32'(syncout), 32'(s));
        chk({tag, "_pcount"},  e, 32'(period_count), 32'(pc));
        chk({tag, "_done"},    e, 32'(done), 32'(d));
        chk({tag, "_busy"},    e, 32'(busy), 32'(b));
    endtask

    // Present start with a config for one edge (edge 0), then scramble config.
    task automatic launch(input logic [31:0] h, input logic [31:0] d, input logic [15:0] n);
        cfg_half_period = h;
        cfg_delay       = d;
        cfg_num_periods = n;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start           = 1'b0;
        cfg_half_period = 32'd7;
        cfg_delay       = 32'd9;
        cfg_num_periods = 16'd5;
    endtask

    // H=3, D=2, N=2: rises 5,11; falls 8,14; done after 14; idle after 15.
    task automatic basic_run(input string tag);
        launch(32'd3, 32'd2, 16'd2);
        chk_all({tag, "_e0"}, 0, 1'b0, 0, 1'b0, 1'b1);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            chk_all(tag, e,
                    ((e >= 5 && e <= 7) || (e >= 11 && e <= 13)),
                    (e < 5) ? 0 : ((e < 11) ? 1 : 2),
                    (e == 14),
                    (e <= 14));
        end
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        cfg_half_period = '0;
        cfg_delay       = '0;
        cfg_num_periods = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic run
        basic_run("basic");

        // Zero delay, H=0 treated as 1, N=3
        launch(32'd0, 32'd0, 16'd3);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk_all("minper", e, (e <= 6) && (e % 2 == 1),
                    (e >= 6) ? 3 : (e + 1) / 2, (e == 6), (e <= 6));
        end

        // Infinite mode H=4, abort sampled at edge 50
        launch(32'd4, 32'd0, 16'd0);
        for (int e = 1; e <= 49; e++) begin
            @(posedge clk);
            #1;
            chk_all("inf", e, ((e / 4) % 2 == 1), (e + 4) / 8, 1'b0, 1'b1);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_all("inf_abort", 50, 1'b0, 6, 1'b0, 1'b0);
        for (int e = 51; e <= 53; e++) begin
            @(posedge clk);
            #1;
            chk_all("inf_after", e, 1'b0, 6, 1'b0, 1'b0);
        end

        // Start during RUN ignored: H=2, D=1, N=2; rises 3,7; falls 5,9
        launch(32'd2, 32'd1, 16'd2);
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) begin
                cfg_half_period = 32'd5;
                cfg_delay       = 32'd0;
                cfg_num_periods = 16'd7;
                start           = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            chk_all("restart", e,
                    ((e >= 3 && e <= 4) || (e >= 7 && e <= 8)),
                    (e < 3) ? 0 : ((e < 7) ? 1 : 2),
                    (e == 9),
                    (e <= 9));
        end

        // Start and abort together in IDLE: stays idle, count held
        start = 1'b1;
        abort = 1'b1;
        cfg_half_period = 32'd1;
        cfg_delay       = 32'd0;
        cfg_num_periods = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk_all("collide", 1, 1'b0, 2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("collide", 2, 1'b0, 2, 1'b0, 1'b0);

        // Abort on terminal-count edge: H=2, D=0, N=1 ends at edge 4
        launch(32'd2, 32'd0, 16'd1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            chk_all("termab", e, (e >= 2), (e >= 2) ? 1 : 0, 1'b0, 1'b1);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_all("termab", 4, 1'b0, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("termab", 5, 1'b0, 1, 1'b0, 1'b0);

        // Async reset mid-run: H=3, D=0, N=0; high after edge 3
        launch(32'd3, 32'd0, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        chk_all("prerst", 4, 1'b1, 1, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("asyncrst", 4, 1'b0, 0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("postrst", 5, 1'b0, 0, 1'b0, 1'b0);

        // Fresh run after reset behaves as the basic case
        basic_run("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_train_sequencer.md
Name: sync_train_sequencer

Overview:
- Run controller for the sync-output clock generator. On a start request it latches a run configuration, waits a programmable delay, then drives a square-wave sync train for a programmed number of periods or indefinitely, and reports completion.
- Unlike the free-running divider/toggle pair, the half-period, start delay and run length are runtime inputs.
- Sits between the acquisition-control logic (start/abort/config) and the syncout pin.

Parameters:
- CNT_W, 32, width of half-period and delay counters.
- NPER_W, 16, width of period-count configuration and status.
- FREQ_CLK, 2000000, default half-period constant exported to the package for software defaults; not used by the RTL datapath.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- start  in  1  run request, sampled only in IDLE.
- abort  in  1  stop request, honoured in every state.
- cfg_half_period  in  CNT_W  clk cycles per syncout half-period (H); 0 treated as 1.
- cfg_delay  in  CNT_W  clk cycles between start and RUN (D).
- cfg_num_periods  in  NPER_W  periods to emit (N); 0 = run until abort.
- busy  out  1  high in DELAY, RUN and DONE.
- done  out  1  one-cycle pulse on normal completion.
- syncout  out  1  sync train.
- period_count  out  NPER_W  rising edges emitted this run.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, syncout=0, period_count=0; counters cleared.
- States: IDLE, DELAY, RUN, DONE.
- Timing reference: edge 0 is the clk edge that samples start=1.
- IDLE: start=1 and abort=0 at edge 0 latches H, D, N, clears period_count, and enters DELAY (D>0) or RUN (D=0). Config inputs are ignored after that edge.
- DELAY: lasts exactly D cycles, then RUN. syncout stays 0.
- RUN, rising edges: the half-period counter runs from the first RUN cycle. syncout toggles every H cycles. Rising edge k (k>=1) is registered at edge D+(2k-1)H, and period_count increments on that same edge.
- RUN, end of run: when N>0, falling edge N is at edge D+2NH. The same edge enters DONE, so syncout always ends low.
- DONE: done=1 for exactly that one cycle, busy=1. Next edge enters IDLE; busy=0 from edge D+2NH+1.
- N=0: RUN never terminates by count. period_count wraps modulo 2^NPER_W.
- H=1: syncout toggles every cycle (period of 2 clk).
- start while not IDLE is ignored; no queuing.
- abort=1 in any non-IDLE state: next edge goes to IDLE with syncout=0, busy=0, done=0. period_count holds its value.
- abort and start both high in IDLE: abort wins, state stays IDLE.
- abort in the same cycle a terminal count would occur: abort wins, no done pulse.
- period_count holds its value after DONE/abort until the next accepted start.
- Reset asserted mid-run: immediate return to reset values; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package sync_pkg holds:
  - state encoding localparams (IDLE=0, DELAY=1, RUN=2, DONE=3);
  - default constants: FREQ_CLK-derived DEFAULT_HALF_PERIOD, DEFAULT_DELAY=0;
  - width defaults.
- Sub-module sync_tick_gen: loadable down-counter with a terminal-count pulse (inputs: clk, reset, load, load_value, enable; output: tick).
  - Instanced once; reused for both the DELAY count and the RUN half-period count, with load issued by the FSM.
  - The FSM, syncout register and period counter live in sync_train_sequencer.

Test Plan:
- Basic run: H=3, D=2, N=2; start at edge 0 -> syncout rises at edge 5, falls at 8, rises at 11, falls at 14; period_count=1 after 5, =2 after 11; done high only for the cycle after edge 14; busy low after edge 15.
- Zero delay/min period: H=0 (treated as 1), D=0, N=3 -> syncout toggles every edge 1..6; done after edge 6; period_count=3.
- Infinite mode: H=4, D=0, N=0; abort at edge 50 -> syncout 0 and busy 0 after edge 50; no done; period_count=6 retained.
- Start ignored while busy: second start pulse during RUN with different cfg -> waveform unchanged from first cfg; exactly one done.
- Abort/start collisions: start and abort both high in IDLE -> stays IDLE, busy=0. Abort on the terminal-count cycle of H=2, N=1 (edge 4) -> no done pulse.
- Async reset mid-run: deassert-to-0 reset between edges during RUN -> all outputs zero immediately (before next clk edge). A fresh start after release behaves as in the basic-run case.
